miller_loop_seq: RTL and testbench
==================================

# miller_loop_seq

Parametrised control sequencer for the Duursma-Lee Miller loop over GF(3^m). It replaces the fixed 97-step one-hot iteration chain and the ad-hoc reset/delay pulses with a counted, start/done-handshaked state machine. It drives the external f3m and f36m multiplier handshakes and emits register-update strobes plus the per-iteration d value (mod 3) to the datapath. It sits between the pairing top level and the loop datapath. It holds no field data itself.

## Interface
- M, default 97: number of loop iterations; must be at least 1.
- DELAY, default 2: idle cycles between entering an iteration and pulsing f3m_start. These cycles give the cubing and ninth-power stages time to settle. Must be at least 1.
- CW, default 7: iteration counter width; must satisfy 2^CW > M.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a loop run; sampled only in IDLE or FINISH.
- abort  in  1  cancel the run in progress and return to IDLE.
- f3m_done  in  1  level done from the base-field multipliers.
- f36m_done  in  1  level done from the extension-field multiplier.
- load  out  1  one-cycle pulse: datapath loads its initial a, b, t, y.
- f3m_start  out  1  one-cycle pulse: starts (and resets) the f3m multipliers.
- f36m_start  out  1  one-cycle pulse: starts the f36m multiplier.
- update  out  1  one-cycle pulse: datapath commits a, b, t, y.
- d_out  out  2  current d in {0,1,2}; encoding 2'b11 never appears.
- iter  out  CW  number of completed iterations.
- busy  out  1  high in every state other than IDLE and FINISH.
- done  out  1  high in FINISH.
- capture  out  1  one-cycle pulse on entry to FINISH: datapath latches its result.

## Operation
- States: IDLE, LOAD, WAIT, F3M, F36M, UPDATE, FINISH.
- IDLE/FINISH with start=1: go to LOAD.
- LOAD, 1 cycle:
  - load=1.
  - d_out<=1, iter<=0.
  - Go to WAIT.
- WAIT: lasts DELAY cycles (internal delay counter), then go to F3M.
- F3M:
  - f3m_start=1 in the first cycle only.
  - Leave on a rising edge of f3m_done, i.e. sampled 1 while the registered previous sample was 0.
  - A done level already high at entry is ignored until it falls and rises again.
- F36M:
  - f36m_start=1 in the first cycle only.
  - Leave on a rising edge of f36m_done, detected the same way.
- UPDATE, 1 cycle:
  - update=1.
  - d_out <= (d_out + 2) mod 3, giving the sequence 1, 0, 2, 1, ...
  - iter <= iter + 1.
  - If the new iter equals M, go to FINISH; otherwise go to WAIT.
- FINISH:
  - done=1.
  - capture=1 in the first cycle only.
  - Holds until start, which re-enters LOAD, or reset.
- start while busy: ignored.
- abort=1 in any busy state:
  - Go to IDLE next cycle.
  - No update or capture is issued that cycle.
  - iter and d_out hold their values; done stays 0.
- abort in IDLE/FINISH: no effect.
- abort and start asserted together: abort wins.
- Done edges on the multiplier not currently awaited are ignored. Both done inputs rising in the same cycle advance only the current state.
- reset=0, at any time including mid-run:
  - Next state is IDLE.
  - All strobes 0.
  - busy=0, done=0, iter=0, d_out=1.
  - Edge-detect registers are cleared to 1, so a done level already high after reset does not count as an edge.

## Timing
- All outputs are registered, or decoded directly from the state register with no input-to-output combinational paths.
- Let start be sampled at edge 0:
  - load is high in cycle 1.
  - WAIT occupies cycles 2 to DELAY+1.
  - f3m_start is high in cycle DELAY+2.
- If the f3m done rise is seen L3 cycles after f3m_start (L3 ≥ 1), f36m_start is high the following cycle.
- With f36m latency L36, update is high the cycle after the f36m done rise.
- Iteration period is DELAY + L3 + L36 + 3 cycles.
- With run period P, done and capture first go high in cycle 2 + M·P.
- iter and d_out change only on the edge that ends UPDATE or LOAD.

## Test plan
- Reset behaviour: M=4, DELAY=2, stub multipliers with L3=5, L36=10; hold reset=0 for 3 cycles → every output at its reset value, iter=0, d_out=1.
- Nominal run (same configuration): start at edge 0 →
  - load in cycle 1, first f3m_start in cycle 4;
  - P=20; update pulses in cycles 21, 41, 61, 81;
  - d_out after each update is 0, 2, 1, 0;
  - capture and done rise in cycle 82; iter=4.
- Stale and crossed dones: f3m_done held high from cycle 0 and dropped one cycle after f3m_start; f36m_done pulsed during F3M → neither advances the state; timing is as in the nominal run once the genuine rises occur.
- Abort: abort during the second F36M → IDLE next cycle; no further update; iter=1; done=0. A subsequent start reloads, with iter=0 and d_out=1 after LOAD.
- Reset mid-run: reset=0 during the third WAIT → IDLE with all outputs at reset values. Start ignored while busy. Start in FINISH restarts cleanly.
- Parametrisation: M=97, DELAY=1, L3=L36=1 → done at cycle 2+97·6=584, iter=97, d_out=0.

Source files
------------

// File: rtl/miller_loop_seq_if.sv
// Handshake and strobe bundle between the Miller-loop sequencer and its
// surroundings (pairing top level, loop datapath, f3m/f36m multipliers).
interface miller_loop_seq_if #(
    parameter int CW = 7
);
    logic          start;
    logic          abort;
    logic          f3m_done;
    logic          f36m_done;
    logic          load;
    logic          f3m_start;
    logic          f36m_start;
    logic          update;
    logic [1:0]    d_out;
    logic [CW-1:0] iter;
    logic          busy;
    logic          done;
    logic          capture;

    modport master (
        input  start, abort, f3m_done, f36m_done,
        output load, f3m_start, f36m_start, update, d_out, iter, busy, done, capture
    );

    modport slave (
        output start, abort, f3m_done, f36m_done,
        input  load, f3m_start, f36m_start, update, d_out, iter, busy, done, capture
    );
endinterface

// File: rtl/miller_loop_seq.sv
// Counted start/done-handshaked sequencer for the Duursma-Lee Miller loop over
// GF(3^m); drives multiplier starts, datapath strobes and the per-iteration d.
module miller_loop_seq #(
    parameter int M     = 97,
    parameter int DELAY = 2,
    parameter int CW    = 7
) (
    input  logic              clk,
    input  logic              reset,
    miller_loop_seq_if.master bus
);
    localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY - 1);
    localparam logic [CW-1:0] ITER_LAST = CW'(M);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_F3M    = 3'd3,
        S_F36M   = 3'd4,
        S_UPDATE = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [DW-1:0] dly_r;
    logic          f3m_prev_r, f36m_prev_r;
    logic [CW-1:0] iter_r, iter_nxt_s, iter_inc_s;
    logic [1:0]    d_r, d_nxt_s;
    logic          load_r, f3m_start_r, f36m_start_r, update_r, busy_r, done_r, capture_r;
    logic          load_nxt_s, f3m_start_nxt_s, f36m_start_nxt_s, update_nxt_s;
    logic          busy_nxt_s, done_nxt_s, capture_nxt_s;
    logic          f3m_rise_s, f36m_rise_s, busy_state_s, abort_hit_s;

    // d walks 1, 0, 2, 1, ... i.e. d + 2 mod 3; 2'b11 is never produced
    function automatic logic [1:0] d_step(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            2'd0:    r = 2'd2;
            2'd1:    r = 2'd0;
            2'd2:    r = 2'd1;
            default: r = 2'd1;
        endcase
        return r;
    endfunction

    assign f3m_rise_s   = bus.f3m_done & ~f3m_prev_r;
    assign f36m_rise_s  = bus.f36m_done & ~f36m_prev_r;
    assign busy_state_s = (state_r != S_IDLE) && (state_r != S_FINISH);
    assign abort_hit_s  = busy_state_s & bus.abort;
    assign iter_inc_s   = iter_r + CW'(1);

    // State register, delay counter, done-edge history and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            dly_r        <= {DW{1'b0}};
            f3m_prev_r   <= 1'b1;
            f36m_prev_r  <= 1'b1;
            iter_r       <= {CW{1'b0}};
            d_r          <= 2'd1;
            load_r       <= 1'b0;
            f3m_start_r  <= 1'b0;
            f36m_start_r <= 1'b0;
            update_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            capture_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dly_r        <= (state_r == S_WAIT) ? dly_r + DW'(1) : {DW{1'b0}};
            f3m_prev_r   <= bus.f3m_done;
            f36m_prev_r  <= bus.f36m_done;
            iter_r       <= iter_nxt_s;
            d_r          <= d_nxt_s;
            load_r       <= load_nxt_s;
            f3m_start_r  <= f3m_start_nxt_s;
            f36m_start_r <= f36m_start_nxt_s;
            update_r     <= update_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            capture_r    <= capture_nxt_s;
        end
    end

    // Next-state decode; abort overrides everything while busy
    always_comb begin
        state_nxt_s = state_r;
        if (abort_hit_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_FINISH: state_nxt_s = bus.start ? S_LOAD : state_r;
                S_LOAD:           state_nxt_s = S_WAIT;
                S_WAIT:           state_nxt_s = (dly_r == DLY_LAST) ? S_F3M : S_WAIT;
                S_F3M:            state_nxt_s = f3m_rise_s ? S_F36M : S_F3M;
                S_F36M:           state_nxt_s = f36m_rise_s ? S_UPDATE : S_F36M;
                S_UPDATE:         state_nxt_s = (iter_inc_s == ITER_LAST) ? S_FINISH : S_WAIT;
                default:          state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state, so strobes line up with the state they belong to
    always_comb begin
        load_nxt_s       = (state_nxt_s == S_LOAD);
        f3m_start_nxt_s  = (state_nxt_s == S_F3M) && (state_r != S_F3M);
        f36m_start_nxt_s = (state_nxt_s == S_F36M) && (state_r != S_F36M);
        update_nxt_s     = (state_nxt_s == S_UPDATE);
        busy_nxt_s       = (state_nxt_s != S_IDLE) && (state_nxt_s != S_FINISH);
        done_nxt_s       = (state_nxt_s == S_FINISH);
        capture_nxt_s    = (state_nxt_s == S_FINISH) && (state_r != S_FINISH);
        iter_nxt_s       = iter_r;
        d_nxt_s          = d_r;
        if (abort_hit_s) begin
            iter_nxt_s = iter_r;
            d_nxt_s    = d_r;
        end else if (state_r == S_LOAD) begin
            iter_nxt_s = {CW{1'b0}};
            d_nxt_s    = 2'd1;
        end else if (state_r == S_UPDATE) begin
            iter_nxt_s = iter_inc_s;
            d_nxt_s    = d_step(d_r);
        end else begin
            iter_nxt_s = iter_r;
            d_nxt_s    = d_r;
        end
    end

    assign bus.load       = load_r;
    assign bus.f3m_start  = f3m_start_r;
    assign bus.f36m_start = f36m_start_r;
    assign bus.update     = update_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.capture    = capture_r;
    assign bus.iter       = iter_r;
    assign bus.d_out      = d_r;
endmodule

// File: tb/tb_miller_loop_seq.sv
// Directed bench for miller_loop_seq: one instance with M=4/DELAY=2 against
// stub multipliers (L3=5, L36=10), one with M=97/DELAY=1 (L3=L36=1).
module tb_miller_loop_seq;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   base = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    miller_loop_seq_if #(.CW(7)) bus_a ();
    miller_loop_seq_if #(.CW(7)) bus_b ();

    miller_loop_seq #(.M(4), .DELAY(2), .CW(7)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    miller_loop_seq #(.M(97), .DELAY(1), .CW(7)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Stub multipliers: done is a level that drops while start is high and rises L cycles later
    int   a3_cnt = 0, a36_cnt = 0, b3_cnt = 0, b36_cnt = 0;
    logic a3_lvl = 1'b0, a36_lvl = 1'b0, b3_lvl = 1'b0, b36_lvl = 1'b0;
    logic a3_force = 1'b0, a36_force = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            a3_cnt <= 0; a3_lvl <= 1'b0; a36_cnt <= 0; a36_lvl <= 1'b0;
        end else begin
            if (bus_a.f3m_start) begin a3_cnt <= 5; a3_lvl <= 1'b0; end
            else if (a3_cnt != 0) begin a3_cnt <= a3_cnt - 1; if (a3_cnt == 1) a3_lvl <= 1'b1; end
            if (bus_a.f36m_start) begin a36_cnt <= 10; a36_lvl <= 1'b0; end
            else if (a36_cnt != 0) begin a36_cnt <= a36_cnt - 1; if (a36_cnt == 1) a36_lvl <= 1'b1; end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            b3_cnt <= 0; b3_lvl <= 1'b0; b36_cnt <= 0; b36_lvl <= 1'b0;
        end else begin
            if (bus_b.f3m_start) begin b3_cnt <= 1; b3_lvl <= 1'b0; end
            else if (b3_cnt != 0) begin b3_cnt <= b3_cnt - 1; if (b3_cnt == 1) b3_lvl <= 1'b1; end
            if (bus_b.f36m_start) begin b36_cnt <= 1; b36_lvl <= 1'b0; end
            else if (b36_cnt != 0) begin b36_cnt <= b36_cnt - 1; if (b36_cnt == 1) b36_lvl <= 1'b1; end
        end
    end

    assign bus_a.f3m_done  = (a3_lvl & ~bus_a.f3m_start) | (a3_cnt == 1) | a3_force;
    assign bus_a.f36m_done = (a36_lvl & ~bus_a.f36m_start) | (a36_cnt == 1) | a36_force;
    assign bus_b.f3m_done  = (b3_lvl & ~bus_b.f3m_start) | (b3_cnt == 1);
    assign bus_b.f36m_done = (b36_lvl & ~bus_b.f36m_start) | (b36_cnt == 1);

    // Output vector order: load, f3m_start, f36m_start, update, busy, done, capture
    logic [6:0] a_out, b_out;
    assign a_out = {bus_a.load, bus_a.f3m_start, bus_a.f36m_start, bus_a.update,
                    bus_a.busy, bus_a.done, bus_a.capture};
    assign b_out = {bus_b.load, bus_b.f3m_start, bus_b.f36m_start, bus_b.update,
                    bus_b.busy, bus_b.done, bus_b.capture};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge inside cycle c of the current run
    task automatic goto(input int c);
        while (cyc - base < c) @(negedge clk);
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        base = cyc;
        goto(1);
        bus_a.start = 1'b0;
    endtask

    logic [1:0] exp_d [4];

    initial begin
        exp_d = '{2'd0, 2'd2, 2'd1, 2'd0};
        reset = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'(a_out), 32'h0);
        chk("reset_iter", 32'(bus_a.iter), 32'd0);
        chk("reset_d", 32'(bus_a.d_out), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run: P = 2 + 5 + 10 + 3 = 20
        start_a();
        chk("nom_load_c1", 32'(a_out), 32'b1000100);
        goto(3);
        chk("nom_wait_c3", 32'(a_out), 32'b0000100);
        goto(4);
        chk("nom_f3m_c4", 32'(a_out), 32'b0100100);
        goto(10);
        chk("nom_f36m_c10", 32'(a_out), 32'b0010100);
        for (int k = 1; k <= 4; k++) begin
            goto(20 * k);
            chk("nom_pre_update", 32'(a_out), 32'b0000100);
            goto(20 * k + 1);
            chk("nom_update", 32'(a_out), 32'b0001100);
            goto(20 * k + 2);
            chk("nom_iter", 32'(bus_a.iter), 32'(k));
            chk("nom_d", 32'(bus_a.d_out), 32'(exp_d[k-1]));
        end
        chk("nom_finish_c82", 32'(a_out), 32'b0000011);
        goto(83);
        chk("nom_hold_c83", 32'(a_out), 32'b0000010);

        // Restart from FINISH, start ignored while busy, reset in third WAIT
        start_a();
        chk("rs_load_c1", 32'(a_out), 32'b1000100);
        goto(2);
        chk("rs_iter_c2", 32'(bus_a.iter), 32'd0);
        chk("rs_d_c2", 32'(bus_a.d_out), 32'd1);
        goto(10);
        chk("rs_f36m_c10", 32'(a_out), 32'b0010100);
        bus_a.start = 1'b1;
        goto(11);
        bus_a.start = 1'b0;
        chk("rs_busy_start_c11", 32'(a_out), 32'b0000100);
        goto(21);
        chk("rs_update_c21", 32'(a_out), 32'b0001100);
        goto(42);
        reset = 1'b0;
        goto(43);
        reset = 1'b1;
        chk("mid_reset_strobes", 32'(a_out), 32'h0);
        chk("mid_reset_iter", 32'(bus_a.iter), 32'd0);
        chk("mid_reset_d", 32'(bus_a.d_out), 32'd1);
        goto(45);

        // Stale f3m level and crossed f36m pulse
        a3_force = 1'b1;
        start_a();
        goto(4);
        chk("st_f3m_c4", 32'(a_out), 32'b0100100);
        goto(5);
        a3_force = 1'b0;
        goto(6);
        a36_force = 1'b1;
        goto(7);
        a36_force = 1'b0;
        chk("st_cross_c7", 32'(a_out), 32'b0000100);
        goto(10);
        chk("st_f36m_c10", 32'(a_out), 32'b0010100);
        goto(21);
        chk("st_update_c21", 32'(a_out), 32'b0001100);

        // Abort in second F36M (cycles 30..40)
        goto(35);
        bus_a.abort = 1'b1;
        goto(36);
        bus_a.abort = 1'b0;
        chk("ab_idle_c36", 32'(a_out), 32'h0);
        chk("ab_iter", 32'(bus_a.iter), 32'd1);
        chk("ab_d", 32'(bus_a.d_out), 32'd0);
        goto(41);
        chk("ab_no_update_c41", 32'(a_out), 32'h0);
        start_a();
        chk("ab_reload_c1", 32'(a_out), 32'b1000100);
        goto(2);
        chk("ab_reload_iter", 32'(bus_a.iter), 32'd0);
        chk("ab_reload_d", 32'(bus_a.d_out), 32'd1);
        goto(3);
        bus_a.abort = 1'b1;
        goto(4);
        bus_a.abort = 1'b0;
        chk("ab_wait_idle_c4", 32'(a_out), 32'h0);

        // M=97, DELAY=1, L3=L36=1: P=6, done at 2+97*6=584
        bus_b.start = 1'b1;
        base = cyc;
        goto(1);
        bus_b.start = 1'b0;
        chk("pb_load_c1", 32'(b_out), 32'b1000100);
        goto(3);
        chk("pb_f3m_c3", 32'(b_out), 32'b0100100);
        goto(583);
        chk("pb_last_update", 32'(b_out), 32'b0001100);
        goto(584);
        chk("pb_finish", 32'(b_out), 32'b0000011);
        chk("pb_iter", 32'(bus_b.iter), 32'd97);
        chk("pb_d", 32'(bus_b.d_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
